// File: rtl/present_decrypt_pkg.sv
// Shared constants, inverse S-box table, FSM states and the
// PRESENT-80 key-register update used by the decrypt core.
package present_decrypt_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 80;
    localparam int ROUNDS = 31;

    // Nibble i of each table lives at bits [4i+3:4i]
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE,
        WHITEN,
        ROUND,
        DONE
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[4*x +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[4*x +: 4];
    endfunction

    // Produces the key register for the following round from the current one
    function automatic logic [79:0] key_update(
        input logic [79:0] k,
        input logic [4:0]  rc
    );
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_decrypt_inv_round.sv
// One combinational PRESENT inverse round: InvP, then InvS, then
// XOR with the round key.
module present_inv_round
    import present_decrypt_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] state_i,
    input  logic [W-1:0] rk_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] perm;
    logic [W-1:0] sub;

    // Bit that encryption moved to P(i) is pulled back to i
    always_comb begin
        perm = '0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                perm[i] = state_i[i];
            end else begin
                perm[i] = state_i[(i * (W / 4)) % (W - 1)];
            end
        end
    end

    always_comb begin
        sub = '0;
        for (int n = 0; n < W / 4; n++) begin
            sub[4*n +: 4] = inv_sbox(perm[4*n +: 4]);
        end
    end

    assign state_o = sub ^ rk_i;

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption core, one inverse round per clock,
// round keys walked from K[ROUNDS] down to K[0].
module present_decrypt
    import present_decrypt_pkg::*;
#(
    parameter int ROUNDS_P = ROUNDS,
    parameter int DATA_W_P = DATA_W,
    parameter int KEY_W_P  = KEY_W
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [KEY_W_P-1:0]  orig_key,
    input  logic [DATA_W_P-1:0] ciphertext,
    output logic [DATA_W_P-1:0] plaintext,
    output logic                Busy,
    output logic                Done
);

    localparam int CW = $clog2(ROUNDS_P);

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [KEY_W_P-1:0]  key_q, key_d;
    logic [DATA_W_P-1:0] data_q, data_d;

    logic [DATA_W_P-1:0] rk [ROUNDS_P+1];
    logic [DATA_W_P-1:0] round_out;

    // All round keys derived combinationally from the held key
    always_comb begin
        logic [KEY_W_P-1:0] k;
        k = key_q;
        for (int j = 0; j <= ROUNDS_P; j++) begin
            rk[j] = k[KEY_W_P-1 -: DATA_W_P];
            if (j < ROUNDS_P) begin
                k = key_update(k, 5'(j + 1));
            end
        end
    end

    present_inv_round #(
        .W(DATA_W_P)
    ) u_inv_round (
        .state_i(data_q),
        .rk_i   (rk[count_q]),
        .state_o(round_out)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        key_d   = key_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    key_d   = orig_key;
                    data_d  = ciphertext;
                    state_d = WHITEN;
                end
            end
            WHITEN: begin
                data_d  = data_q ^ rk[ROUNDS_P];
                count_d = CW'(ROUNDS_P - 1);
                state_d = ROUND;
            end
            ROUND: begin
                data_d = round_out;
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    assign plaintext = data_q;
    assign Busy      = (state_q == WHITEN) || (state_q == ROUND);
    assign Done      = (state_q == DONE);

endmodule
